// File: rtl/avalon_hex_pkg.sv
// Shared constants for the Avalon hex display controller: register map,
// reset values, blank code and the active-low 7-segment glyph table.
package avalon_hex_pkg;

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_ENABLE = 2'd1;
  localparam logic [1:0] ADDR_BLINK  = 2'd2;
  localparam logic [1:0] ADDR_STATUS = 2'd3;

  localparam logic [6:0] BLANK_CODE = 7'h7F;
  localparam logic [5:0] ENABLE_RST = 6'h3F;

  // Index n holds the glyph for nibble n; bit0 = segment a .. bit6 = segment g.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

endpackage

// File: rtl/hex7seg.sv
// Combinational nibble to active-low 7-segment decoder.
module hex7seg
  import avalon_hex_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [6:0] o_seg
);

  assign o_seg = SEG_TABLE[i_nibble];

endmodule

// File: rtl/avalon_hex_ctrl.sv
// Avalon-MM responder driving six 7-segment digits with per-digit enable and blink.
// The blink counter, BLINK and STATUS registers exist only with AVALON_HEX_BLINK_EN defined.
module avalon_hex_ctrl
  import avalon_hex_pkg::*;
#(
  parameter int unsigned BLINK_DIV = 25000000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  avs_address,
  input  logic        avs_read,
  input  logic        avs_write,
  input  logic [31:0] avs_writedata,
  input  logic [3:0]  avs_byteenable,
  output logic [31:0] avs_readdata,
  output logic        avs_readdatavalid,
  output logic [6:0]  hex0,
  output logic [6:0]  hex1,
  output logic [6:0]  hex2,
  output logic [6:0]  hex3,
  output logic [6:0]  hex4,
  output logic [6:0]  hex5
);

  logic [23:0] r_data;
  logic [5:0]  r_enable;
  logic        r_rdvalid;
  logic [31:0] r_rddata;
  logic [6:0]  r_hex [6];
  logic [6:0]  w_glyph [6];
  logic [5:0]  w_blink_rd;
  logic        w_phase_rd;
  logic [5:0]  w_blink_blank;
  logic [31:0] w_rdmux;
  logic        w_rd_accept;
  logic        w_unused;

  if (BLINK_DIV < 2 || BLINK_DIV > 67108863) begin : g_bad_div
    $error("BLINK_DIV out of range 2..2^26-1");
  end

  // A simultaneous write wins; the read is dropped.
  assign w_rd_accept = avs_read && !avs_write;
  assign w_unused    = ^{avs_writedata[31:24], avs_byteenable[3]};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_data   <= '0;
      r_enable <= ENABLE_RST;
    end else if (avs_write) begin
      if (avs_address == ADDR_DATA) begin
        if (avs_byteenable[0]) r_data[7:0]   <= avs_writedata[7:0];
        if (avs_byteenable[1]) r_data[15:8]  <= avs_writedata[15:8];
        if (avs_byteenable[2]) r_data[23:16] <= avs_writedata[23:16];
      end
      if (avs_address == ADDR_ENABLE && avs_byteenable[0]) begin
        r_enable <= avs_writedata[5:0];
      end
    end
  end

`ifdef AVALON_HEX_BLINK_EN
  localparam logic [25:0] DIV_LAST = 26'(BLINK_DIV - 1);

  logic [5:0]  r_blink;
  logic [25:0] r_cnt;
  logic        r_phase;

  // A STATUS write restarts the half-period with digits visible.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_blink <= '0;
      r_cnt   <= '0;
      r_phase <= 1'b1;
    end else begin
      if (avs_write && avs_address == ADDR_BLINK && avs_byteenable[0]) begin
        r_blink <= avs_writedata[5:0];
      end
      if (avs_write && avs_address == ADDR_STATUS) begin
        r_cnt   <= '0;
        r_phase <= 1'b1;
      end else if (r_cnt == DIV_LAST) begin
        r_cnt   <= '0;
        r_phase <= ~r_phase;
      end else begin
        r_cnt <= r_cnt + 26'd1;
      end
    end
  end

  assign w_blink_rd    = r_blink;
  assign w_phase_rd    = r_phase;
  assign w_blink_blank = r_blink & {6{~r_phase}};
`else
  assign w_blink_rd    = '0;
  assign w_phase_rd    = 1'b0;
  assign w_blink_blank = '0;
`endif

  always_comb begin
    w_rdmux = '0;
    case (avs_address)
      ADDR_DATA:   w_rdmux = {8'h00, r_data};
      ADDR_ENABLE: w_rdmux = {26'd0, r_enable};
      ADDR_BLINK:  w_rdmux = {26'd0, w_blink_rd};
      ADDR_STATUS: w_rdmux = {31'd0, w_phase_rd};
      default:     w_rdmux = '0;
    endcase
  end

  // Fixed one-cycle read latency; data holds between valid pulses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rdvalid <= 1'b0;
      r_rddata  <= '0;
    end else begin
      r_rdvalid <= w_rd_accept;
      if (w_rd_accept) r_rddata <= w_rdmux;
    end
  end

  for (genvar gi = 0; gi < 6; gi++) begin : g_digit
    hex7seg u_hex7seg (
      .i_nibble (r_data[4*gi +: 4]),
      .o_seg    (w_glyph[gi])
    );
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 6; i++) r_hex[i] <= SEG_TABLE[0];
    end else begin
      for (int i = 0; i < 6; i++) begin
        r_hex[i] <= (!r_enable[i] || w_blink_blank[i]) ? BLANK_CODE : w_glyph[i];
      end
    end
  end

  assign avs_readdata      = r_rddata;
  assign avs_readdatavalid = r_rdvalid;
  assign hex0 = r_hex[0];
  assign hex1 = r_hex[1];
  assign hex2 = r_hex[2];
  assign hex3 = r_hex[3];
  assign hex4 = r_hex[4];
  assign hex5 = r_hex[5];

endmodule

// File: tb/tb_avalon_hex_ctrl.sv
// Directed self-checking bench for avalon_hex_ctrl (BLINK_DIV=4); expectations
// adapt to whether AVALON_HEX_BLINK_EN is defined.
module tb_avalon_hex_ctrl;
  import avalon_hex_pkg::*;

`ifdef AVALON_HEX_BLINK_EN
  localparam bit BLINK_EN = 1'b1;
`else
  localparam bit BLINK_EN = 1'b0;
`endif
  localparam int unsigned DIV = 4;
  localparam logic [5:0][6:0] RST_HEX = {7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic [1:0]  avs_address;
  logic        avs_read;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic [3:0]  avs_byteenable;
  logic [31:0] avs_readdata;
  logic        avs_readdatavalid;
  logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5;
  logic [5:0][6:0] w_hex;

  int n_checks = 0;
  int n_fail   = 0;

  avalon_hex_ctrl #(.BLINK_DIV(DIV)) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .avs_address       (avs_address),
    .avs_read          (avs_read),
    .avs_write         (avs_write),
    .avs_writedata     (avs_writedata),
    .avs_byteenable    (avs_byteenable),
    .avs_readdata      (avs_readdata),
    .avs_readdatavalid (avs_readdatavalid),
    .hex0              (hex0),
    .hex1              (hex1),
    .hex2              (hex2),
    .hex3              (hex3),
    .hex4              (hex4),
    .hex5              (hex5)
  );

  // clock / reset
  always #5 clk = ~clk;
  assign w_hex = {hex5, hex4, hex3, hex2, hex1, hex0};

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  // scoreboard
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_hex(input string tag, input logic [5:0][6:0] exp);
    for (int i = 0; i < 6; i++) begin
      check_eq($sformatf("%s_hex%0d", tag, i), 32'(w_hex[i]), 32'(exp[i]));
    end
  endtask

  // drivers: called at a falling edge, return at a falling edge after the sampling edge
  task automatic bus_write(input logic [1:0] addr, input logic [31:0] data, input logic [3:0] be);
    avs_address    = addr;
    avs_writedata  = data;
    avs_byteenable = be;
    avs_write      = 1'b1;
    @(negedge clk);
    avs_write      = 1'b0;
    avs_byteenable = 4'h0;
  endtask

  task automatic bus_read(input logic [1:0] addr, input logic [31:0] exp, input string tag);
    avs_address = addr;
    avs_read    = 1'b1;
    @(negedge clk);
    check_eq({tag, "_rdv"}, 32'(avs_readdatavalid), 32'd1);
    check_eq(tag, avs_readdata, exp);
    avs_read = 1'b0;
    @(negedge clk);
    check_eq({tag, "_rdv_low"}, 32'(avs_readdatavalid), 32'd0);
    check_eq({tag, "_hold"}, avs_readdata, exp);
  endtask

  initial begin
    logic [31:0] exp_status;
    logic [6:0]  exp_hex0;
    avs_address    = '0;
    avs_read       = 1'b0;
    avs_write      = 1'b0;
    avs_writedata  = '0;
    avs_byteenable = '0;

    // asynchronous reset takes effect before any clock edge
    #1 reset_n = 1'b0;
    #1;
    check_eq("rst_rdv", 32'(avs_readdatavalid), 32'd0);
    check_eq("rst_rddata", avs_readdata, 32'd0);
    check_hex("rst", RST_HEX);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    // first edge after release already accepts a read
    bus_read(ADDR_STATUS, BLINK_EN ? 32'd1 : 32'd0, "init_status");
    bus_read(ADDR_DATA,   32'h0000_0000, "init_data");
    bus_read(ADDR_ENABLE, 32'h0000_003F, "init_enable");
    bus_read(ADDR_BLINK,  32'h0000_0000, "init_blink");
    check_hex("init", RST_HEX);

    // partial byte-enable write to DATA
    bus_write(ADDR_DATA, 32'h00AB_CDEF, 4'b0011);
    check_hex("be_edge_k", RST_HEX);
    @(negedge clk);
    check_hex("be", {7'h40, 7'h40, 7'h46, 7'h21, 7'h06, 7'h0E});
    bus_read(ADDR_DATA, 32'h0000_CDEF, "be_data");

    // ENABLE blanking
    bus_write(ADDR_ENABLE, 32'h0000_0005, 4'hF);
    @(negedge clk);
    check_hex("enable", {7'h7F, 7'h7F, 7'h7F, 7'h21, 7'h7F, 7'h0E});
    bus_read(ADDR_ENABLE, 32'h0000_0005, "enable_rd");

    // blink digit 0; phase restarts at 1 on the STATUS write
    bus_write(ADDR_BLINK, 32'hFFFF_FFC1, 4'h1);
    bus_read(ADDR_BLINK, BLINK_EN ? 32'd1 : 32'd0, "blink_rd");
    bus_write(ADDR_STATUS, 32'hDEAD_BEEF, 4'hF);
    avs_address = ADDR_STATUS;
    avs_read    = 1'b1;
    for (int m = 1; m <= 12; m++) begin
      @(negedge clk);
      exp_status = (BLINK_EN && (((m - 1) / 4) % 2 == 1)) ? 32'd0 : (BLINK_EN ? 32'd1 : 32'd0);
      exp_hex0   = (BLINK_EN && (((m - 1) / 4) % 2 == 1)) ? 7'h7F : 7'h0E;
      check_eq($sformatf("blink_hex0_m%0d", m), 32'(hex0), 32'(exp_hex0));
      check_eq($sformatf("blink_status_m%0d", m), avs_readdata, exp_status);
      check_eq($sformatf("blink_rdv_m%0d", m), 32'(avs_readdatavalid), 32'd1);
    end
    avs_read = 1'b0;
    @(negedge clk);

    // read and write together: write performed, read dropped
    avs_address    = ADDR_DATA;
    avs_writedata  = 32'h0012_3456;
    avs_byteenable = 4'hF;
    avs_read       = 1'b1;
    avs_write      = 1'b1;
    @(negedge clk);
    check_eq("rw_rdv", 32'(avs_readdatavalid), 32'd0);
    avs_read       = 1'b0;
    avs_write      = 1'b0;
    avs_byteenable = 4'h0;
    bus_read(ADDR_DATA, 32'h0012_3456, "rw_data");

    // reset pulsed while a read is in flight
    avs_address = ADDR_DATA;
    avs_read    = 1'b1;
    @(posedge clk);
    #1;
    reset_n  = 1'b0;
    avs_read = 1'b0;
    #1;
    check_eq("midrst_rdv", 32'(avs_readdatavalid), 32'd0);
    check_eq("midrst_rddata", avs_readdata, 32'd0);
    check_hex("midrst", RST_HEX);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check_eq($sformatf("post_rst_rdv_%0d", c), 32'(avs_readdatavalid), 32'd0);
    end
    bus_read(ADDR_STATUS, BLINK_EN ? 32'd1 : 32'd0, "post_rst_status");
    bus_read(ADDR_DATA,   32'h0000_0000, "post_rst_data");
    bus_read(ADDR_ENABLE, 32'h0000_003F, "post_rst_enable");
    bus_read(ADDR_BLINK,  32'h0000_0000, "post_rst_blink");
    check_hex("post_rst", RST_HEX);

    // report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
